// File: rtl/speed_round_ctrl.sv
// Speed-round sequencer: prep countdown, timed push window, settle, decide, counter clear.
// Latency: every output is registered and follows the state it belongs to, with no input-to-output path.
// Backpressure: none. A start arriving while busy (EXIT included) is dropped, not queued.
module speed_round_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PREP_SECS     = 3,
    parameter int ROUND_SECS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       speed_right,
    input  logic       speed_tie,
    output logic       speedRound,
    output logic       speedExit,
    output logic       win_left,
    output logic       win_right,
    output logic       win_tie,
    output logic       busy,
    output logic [3:0] secs_left
);

    localparam int              TW         = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0]   TICK_ONE   = TW'(1);
    localparam logic [3:0]      PREP_LOAD  = 4'(PREP_SECS);
    localparam logic [3:0]      ROUND_LOAD = 4'(ROUND_SECS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        ROUND  = 3'd2,
        SETTLE = 3'd3,
        DECIDE = 3'd4,
        EXIT   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nxt;
    logic [3:0]    sec_cnt;
    logic [3:0]    sec_nxt;
    logic          tick_wrap;
    logic          last_sec;

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign last_sec  = (sec_cnt == 4'd1);

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        sec_nxt   = sec_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PREP;
                    sec_nxt   = PREP_LOAD;
                    tick_nxt  = '0;
                end
            end
            PREP, ROUND: begin
                if (tick_wrap) begin
                    tick_nxt = '0;
                    // The final second hands over instead of decrementing, so sec_cnt never reaches 0 here.
                    if (last_sec) begin
                        if (state == PREP) begin
                            state_nxt = ROUND;
                            sec_nxt   = ROUND_LOAD;
                        end else begin
                            state_nxt = SETTLE;
                            sec_nxt   = 4'd0;
                        end
                    end else begin
                        sec_nxt = sec_cnt - 4'd1;
                    end
                end else begin
                    tick_nxt = tick_cnt + TICK_ONE;
                end
            end
            SETTLE: begin
                // tick_cnt doubles as the two-cycle settle timer for the counter's registered compare.
                if (tick_cnt != '0) begin
                    state_nxt = DECIDE;
                    tick_nxt  = '0;
                end else begin
                    tick_nxt = TICK_ONE;
                end
            end
            DECIDE:  state_nxt = EXIT;
            EXIT:    state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                tick_nxt  = '0;
                sec_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            sec_cnt    <= 4'd0;
            speedRound <= 1'b0;
            speedExit  <= 1'b0;
            win_left   <= 1'b0;
            win_right  <= 1'b0;
            win_tie    <= 1'b0;
            busy       <= 1'b0;
            secs_left  <= 4'd0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            sec_cnt    <= sec_nxt;
            speedRound <= (state_nxt == ROUND);
            speedExit  <= (state_nxt == EXIT);
            busy       <= (state_nxt != IDLE);
            secs_left  <= ((state_nxt == PREP) || (state_nxt == ROUND)) ? sec_nxt : 4'd0;
            win_tie    <= (state_nxt == DECIDE) && speed_tie;
            win_right  <= (state_nxt == DECIDE) && !speed_tie && speed_right;
            win_left   <= (state_nxt == DECIDE) && !speed_tie && !speed_right;
        end
    end

endmodule
